clock_core: RTL and testbench

Free-running time-of-day counter. Holds the current hour/minute/second, advances once per prescaled second tick, and lets the user set the time field by field with increase/decrease pulses. Sits directly upstream of the alarm comparator: its `cur_hour`/`cur_minute`/`cur_second` outputs feed the alarm block's current-time inputs, and its `tick` output marks each time update.

---
 rtl/clock_core.sv | 154 +++++++++++++++
 tb/tb_clock_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core.sv
// rtl/clock_core.sv - time-of-day counter with prescaled tick and field-wise set (option: CLOCK_CORE_SEC_CLEAR_EN)
module clock_core #(
    parameter int CLK_DIV = 4,
    parameter int HOUR    = 24,
    parameter int MINUTE  = 60,
    parameter int SECOND  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set_mode,
    input  logic [2:0] signal_increase,
    input  logic [2:0] signal_decrease,
    output logic [7:0] cur_second,
    output logic [7:0] cur_minute,
    output logic [7:0] cur_hour,
    output logic       tick,
    output logic       day_wrap
);

    localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);
    localparam logic [7:0]  SEC_MAX   = 8'(SECOND - 1);
    localparam logic [7:0]  MIN_MAX   = 8'(MINUTE - 1);
    localparam logic [7:0]  HOUR_MAX  = 8'(HOUR - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_SET
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] presc;
    logic [2:0]  inc_vec;
    logic [2:0]  dec_vec;
    logic        update;
    logic [7:0]  sec_base;
    logic [7:0]  sec_n;
    logic [7:0]  min_n;
    logic [7:0]  hour_n;
    logic        wrap_n;
`ifdef CLOCK_CORE_SEC_CLEAR_EN
    logic        leave_set;
`endif

    // Single-step wrap-around adjust of one field; up wins over down.
    function automatic logic [7:0] adjust_field(input logic [7:0] val, input logic [7:0] max,
                                                input logic up, input logic down);
        if (up)
            return (val == max) ? 8'd0 : val + 8'd1;
        else if (down)
            return (val == 8'd0) ? max : val - 8'd1;
        else
            return val;
    endfunction

    // State register; the mode takes effect on the same edge its inputs are sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_STOP;
        else
            state <= next_state;
    end

    // Mode decode and pulse selection: any increase bit masks the whole decrease vector.
    always_comb begin
        next_state = ST_STOP;
        inc_vec    = 3'b000;
        dec_vec    = 3'b000;
        if (set_mode)
            next_state = ST_SET;
        else if (en)
            next_state = ST_RUN;
        if (next_state == ST_SET) begin
            if (|signal_increase)
                inc_vec = signal_increase;
            else
                dec_vec = signal_decrease;
        end
    end

    assign update = (next_state == ST_RUN) && (presc == PRESC_MAX);

`ifdef CLOCK_CORE_SEC_CLEAR_EN
    assign leave_set = (state == ST_SET) && (next_state != ST_SET);
`endif

    // Next time value: full carry ripple on a counted update, independent field adjust otherwise.
    always_comb begin
        sec_base = cur_second;
`ifdef CLOCK_CORE_SEC_CLEAR_EN
        if (leave_set)
            sec_base = 8'd0;
`endif
        sec_n  = sec_base;
        min_n  = cur_minute;
        hour_n = cur_hour;
        wrap_n = 1'b0;
        if (update) begin
            if (sec_base == SEC_MAX) begin
                sec_n = 8'd0;
                if (cur_minute == MIN_MAX) begin
                    min_n = 8'd0;
                    if (cur_hour == HOUR_MAX) begin
                        hour_n = 8'd0;
                        wrap_n = 1'b1;
                    end else begin
                        hour_n = cur_hour + 8'd1;
                    end
                end else begin
                    min_n = cur_minute + 8'd1;
                end
            end else begin
                sec_n = sec_base + 8'd1;
            end
        end else begin
            sec_n  = adjust_field(sec_base, SEC_MAX, inc_vec[0], dec_vec[0]);
            min_n  = adjust_field(cur_minute, MIN_MAX, inc_vec[1], dec_vec[1]);
            hour_n = adjust_field(cur_hour, HOUR_MAX, inc_vec[2], dec_vec[2]);
        end
    end

    // Prescaler: counts in RUN, holds in STOP, cleared while setting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= 16'd0;
        end else begin
            case (next_state)
                ST_SET:  presc <= 16'd0;
                ST_RUN:  presc <= update ? 16'd0 : presc + 16'd1;
                default: presc <= presc;
            endcase
        end
    end

    // Time registers and the registered update strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_second <= 8'd0;
            cur_minute <= 8'd0;
            cur_hour   <= 8'd0;
            tick       <= 1'b0;
            day_wrap   <= 1'b0;
        end else begin
            cur_second <= sec_n;
            cur_minute <= min_n;
            cur_hour   <= hour_n;
            tick       <= update;
            day_wrap   <= wrap_n;
        end
    end

endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - randomized and directed bench for clock_core against a seconds-of-day model
module tb_clock_core;

    localparam int CLK_DIV = 4;
    localparam int HOUR    = 24;
    localparam int MINUTE  = 60;
    localparam int SECOND  = 60;
`ifdef CLOCK_CORE_SEC_CLEAR_EN
    localparam bit SEC_CLEAR = 1'b1;
`else
    localparam bit SEC_CLEAR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       set_mode;
    logic [2:0] signal_increase;
    logic [2:0] signal_decrease;
    logic [7:0] cur_second;
    logic [7:0] cur_minute;
    logic [7:0] cur_hour;
    logic       tick;
    logic       day_wrap;

    int tests_run;
    int tests_failed;

    int m_h, m_m, m_s, m_pc;
    bit m_tick, m_wrap, m_prev_set;

    clock_core #(
        .CLK_DIV(CLK_DIV),
        .HOUR   (HOUR),
        .MINUTE (MINUTE),
        .SECOND (SECOND)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .set_mode       (set_mode),
        .signal_increase(signal_increase),
        .signal_decrease(signal_decrease),
        .cur_second     (cur_second),
        .cur_minute     (cur_minute),
        .cur_hour       (cur_hour),
        .tick           (tick),
        .day_wrap       (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_time(input int h, input int m, input int s);
        return {8'd0, 8'(h), 8'(m), 8'(s)};
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_pc = 0;
        m_tick = 0; m_wrap = 0; m_prev_set = 0;
    endtask

    // Behavioural model: time kept as seconds-of-day for counting, modular arithmetic for setting.
    task automatic model_edge(input bit sm, input bit e, input logic [2:0] inc, input logic [2:0] dec);
        int t;
        logic [2:0] v;
        int d;
        m_tick = 0;
        m_wrap = 0;
        if (sm) begin
            m_pc = 0;
            v = (inc != 0) ? inc : dec;
            d = (inc != 0) ? 1 : -1;
            if (v[0]) m_s = (m_s + d + SECOND) % SECOND;
            if (v[1]) m_m = (m_m + d + MINUTE) % MINUTE;
            if (v[2]) m_h = (m_h + d + HOUR) % HOUR;
        end else begin
            if (m_prev_set && SEC_CLEAR) m_s = 0;
            if (e) begin
                if (m_pc == CLK_DIV - 1) begin
                    m_pc = 0;
                    t = (m_h * MINUTE + m_m) * SECOND + m_s + 1;
                    if (t == HOUR * MINUTE * SECOND) begin
                        t = 0;
                        m_wrap = 1;
                    end
                    m_s = t % SECOND;
                    m_m = (t / SECOND) % MINUTE;
                    m_h = t / (SECOND * MINUTE);
                    m_tick = 1;
                end else begin
                    m_pc++;
                end
            end
        end
        m_prev_set = sm;
    endtask

    // One clock: drive, let the edge happen, advance the model, compare just after the edge.
    task automatic step(input bit sm, input bit e, input logic [2:0] inc, input logic [2:0] dec);
        set_mode = sm;
        en = e;
        signal_increase = inc;
        signal_decrease = dec;
        @(posedge clk);
        model_edge(sm, e, inc, dec);
        #1;
        check("time", pack_time(cur_hour, cur_minute, cur_second), pack_time(m_h, m_m, m_s));
        check("tick", {31'd0, tick}, {31'd0, m_tick});
        check("day_wrap", {31'd0, day_wrap}, {31'd0, m_wrap});
    endtask

    task automatic pulse_n(input int n, input logic [2:0] inc, input logic [2:0] dec);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, inc, dec);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_time", pack_time(cur_hour, cur_minute, cur_second), 32'd0);
        check("rst_tick", {30'd0, tick, day_wrap}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bit sm_r, en_r;
        logic [2:0] inc_r, dec_r;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        en = 1'b0;
        set_mode = 1'b0;
        signal_increase = 3'b000;
        signal_decrease = 3'b000;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_time", pack_time(cur_hour, cur_minute, cur_second), 32'd0);
        check("reset_strobes", {30'd0, tick, day_wrap}, 32'd0);
        rst = 1'b0;

        // Counting from reset: ticks on cycles 4, 8, 12.
        for (int c = 1; c <= 12; c++) begin
            step(1'b0, 1'b1, 3'b000, 3'b000);
            if (c % 4 == 0) begin
                check("count_tick", {31'd0, tick}, 32'd1);
                check("count_sec", {24'd0, cur_second}, 32'(c / 4));
            end
        end
        // Partial count, pause with pulses ignored, resume from held prescaler.
        step(1'b0, 1'b1, 3'b000, 3'b000);
        step(1'b0, 1'b1, 3'b000, 3'b000);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 3'b111, 3'b000);
        check("stop_hold", pack_time(cur_hour, cur_minute, cur_second), pack_time(0, 0, 3));
        step(1'b0, 1'b1, 3'b001, 3'b000);
        step(1'b0, 1'b1, 3'b000, 3'b010);
        check("resume_tick", {31'd0, tick}, 32'd1);
        check("resume_sec", {24'd0, cur_second}, 32'd4);

        // Async reset mid-count at 05:17:33.
        async_reset();
        pulse_n(19, 3'b000, 3'b100);
        pulse_n(43, 3'b000, 3'b010);
        pulse_n(27, 3'b000, 3'b001);
        check("set_051733", pack_time(cur_hour, cur_minute, cur_second), pack_time(5, 17, 33));
        step(1'b0, 1'b1, 3'b000, 3'b000);
        step(1'b0, 1'b1, 3'b000, 3'b000);
        #2;
        async_reset();

        // Adjust wrap and full roll-over.
        pulse_n(1, 3'b000, 3'b111);
        check("dec_wrap", pack_time(cur_hour, cur_minute, cur_second), pack_time(23, 59, 59));
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 3'b000, 3'b000);
        if (SEC_CLEAR) begin
            check("roll_time", pack_time(cur_hour, cur_minute, cur_second), pack_time(23, 59, 1));
            check("roll_wrap", {30'd0, tick, day_wrap}, 32'b10);
        end else begin
            check("roll_time", pack_time(cur_hour, cur_minute, cur_second), pack_time(0, 0, 0));
            check("roll_wrap", {30'd0, tick, day_wrap}, 32'b11);
        end
        step(1'b0, 1'b1, 3'b000, 3'b000);
        check("roll_one_cycle", {30'd0, tick, day_wrap}, 32'd0);
        async_reset();
        pulse_n(1, 3'b000, 3'b111);
        pulse_n(1, 3'b010, 3'b000);
        check("inc_wrap", pack_time(cur_hour, cur_minute, cur_second), pack_time(23, 0, 59));
        pulse_n(1, 3'b000, 3'b010);
        pulse_n(11, 3'b000, 3'b100);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 3'b000, 3'b000);
        if (SEC_CLEAR)
            check("noon_roll", pack_time(cur_hour, cur_minute, cur_second), pack_time(12, 59, 1));
        else
            check("noon_roll", pack_time(cur_hour, cur_minute, cur_second), pack_time(13, 0, 0));
        check("noon_wrap", {31'd0, day_wrap}, 32'd0);

        // Simultaneous increase/decrease pulses at 10:10:10.
        async_reset();
        pulse_n(10, 3'b111, 3'b000);
        pulse_n(1, 3'b001, 3'b100);
        check("simul_pulse", pack_time(cur_hour, cur_minute, cur_second), pack_time(10, 10, 11));

        // Exit from SET at 08:30:45.
        async_reset();
        pulse_n(8, 3'b111, 3'b000);
        pulse_n(22, 3'b010, 3'b000);
        pulse_n(37, 3'b001, 3'b000);
        step(1'b0, 1'b1, 3'b000, 3'b000);
        check("set_exit", pack_time(cur_hour, cur_minute, cur_second),
              SEC_CLEAR ? pack_time(8, 30, 0) : pack_time(8, 30, 45));

        // Randomized run with sticky modes and occasional async reset.
        sm_r = 0;
        en_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) sm_r = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) en_r = ($urandom_range(0, 3) != 0);
            inc_r = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            dec_r = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(sm_r, en_r, inc_r, dec_r);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
